verdict_stream_collector: RTL and testbench
===========================================

Name: verdict_stream_collector

Overview:
Output-side counterpart to the monitor's stimulus path. It samples the monitor's per-stream outputs and their active flags every cycle, and stamps each active cycle with a free-running cycle counter. Records go into a FIFO and are serialized onto a ready/valid word stream for a host or logger. It sits directly behind topEntity and replaces ad-hoc $display-based verdict capture in synthesized builds.

Parameters:
NUM_OUTPUTS, 3, number of monitor output streams (1..16)
DATA_W, 64, width of each output value and of the stream word
TS_W, 32, timestamp counter width; TS_W+NUM_OUTPUTS <= DATA_W
DEPTH, 16, FIFO depth in records, power of two >= 2

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on the clock edge)
en  in  1  capture/timestamp enable, same signal as the monitor's en
out_val  in  NUM_OUTPUTS*DATA_W  monitor outputs flattened, stream i at [i*DATA_W +: DATA_W], signed
out_aktv  in  NUM_OUTPUTS  per-stream active flags
m_data  out  DATA_W  stream word
m_valid  out  1  m_data valid
m_last  out  1  final word of the current record
m_ready  in  1  downstream accepts the word when m_valid & m_ready
overflow  out  1  sticky: a record was dropped
fifo_level  out  clog2(DEPTH)+1  records currently stored

Behaviour:
- Reset (rst=0 at an edge): ts=0, FIFO empty, FSM=IDLE, m_valid=0, m_last=0, m_data=0, overflow=0, fifo_level=0.
- Reset mid-record discards the partial record and all queued records. m_valid is 0 in the cycle after the reset edge.
- Timestamp: ts increments by 1 on each edge with en=1 and wraps modulo 2^TS_W. It holds when en=0.
- Capture: at an edge with en=1 and |out_aktv, push record {ts (pre-increment value), out_aktv, out_val}. Nothing is captured when en=0 or out_aktv=0.
- Full FIFO: push is evaluated against the occupancy before any same-cycle pop. A push into a full FIFO is dropped, sets overflow, and leaves the FIFO unchanged.
- Draining is not gated by en.
- Header word: m_data[DATA_W-1 -: TS_W]=ts, m_data[NUM_OUTPUTS-1:0]=aktv mask, all other bits 0.
- Value word: the raw DATA_W value of one active stream.
- Record order on the stream: header first, then one value word per set mask bit, in ascending stream index.
- Per-record word count is 1 + popcount(mask). m_last is asserted only on the final value word.
- FSM IDLE: if the FIFO is non-empty, pop the head into a shadow register and go to HDR. m_valid=0 in IDLE.
- FSM HDR: present the header. On handshake, set idx to the lowest set mask bit and go to DATA.
- FSM DATA: present value[idx]. On handshake, if higher mask bits remain, set idx to the next set bit; otherwise go to IDLE.
- Minimum spacing: one idle cycle between records.
- Stream rules: m_data and m_last are stable while m_valid=1 and m_ready=0. m_valid never drops without a handshake.
- Latency: aktv sampled at edge t gives a header with m_valid=1 after edge t+2, provided the FIFO was empty and the FSM was in IDLE.
- fifo_level updates on the edge of the push or pop. A simultaneous push and pop on a non-full FIFO leaves the level unchanged.
- No arithmetic is applied to values; they are passed bit-exact, including sign.

Optional Feature:
Macro COLLECTOR_DROP_CNT_EN.
- Defined: adds output drop_cnt (16 bits), which counts dropped records and saturates at 16'hFFFF. It is cleared only by reset.
- Defined: in the first header emitted after any drop, bit NUM_OUTPUTS of the header is set to 1 as a gap marker. The marker is cleared once that header is accepted.
- Undefined: no drop_cnt port and header bit NUM_OUTPUTS is always 0. overflow still behaves as specified.

Test Plan:
- Reset, hold rst=1 and en=1 for 5 cycles, then aktv=3'b111 with values (1,1,1) for one cycle at ts=5 -> 4 words: header with ts=5 and mask=7, then 1, 1, 1; m_last only on the 4th word; first m_valid two edges after capture.
- Single aktv=3'b010 with value 6 while m_ready is held at 0 for 10 cycles -> header and data stay stable; then 2 words (header mask=2, value 6 with m_last); fifo_level returns to 0.
- m_ready=0 and 18 consecutive active cycles with DEPTH=16 -> fifo_level=16, records 17 and 18 dropped, overflow=1 sticky; draining yields exactly 16 records with ts consecutive.
- Negative value -5 (64'hFFFF_FFFF_FFFF_FFFB) on stream 2 with mask 3'b100 -> value word is bit-exact; header low bits = 3'b100.
- en=0 for 7 cycles with aktv toggling -> no records and ts unchanged; after en=1 returns, the next header ts equals the pre-pause value plus elapsed enabled cycles.
- Assert rst=0 in DATA state mid-record -> next cycle m_valid=0, fifo_level=0, overflow=0; a new capture afterwards produces a record with ts counted from 0.

Source files
------------

// File: rtl/verdict_stream_collector.sv
// Captures active monitor outputs with a cycle timestamp, queues them and serializes each record as header + value words.
// Optional drop counter and header gap marker: define COLLECTOR_DROP_CNT_EN.
module verdict_stream_collector #(
  parameter int NUM_OUTPUTS = 3,
  parameter int DATA_W      = 64,
  parameter int TS_W        = 32,
  parameter int DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_OUTPUTS*DATA_W-1:0] out_val,
  input  logic [NUM_OUTPUTS-1:0]        out_aktv,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic                          overflow,
  output logic [$clog2(DEPTH):0]        fifo_level
`ifdef COLLECTOR_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int IDX_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int VALS_W = NUM_OUTPUTS * DATA_W;
  localparam int REC_W  = TS_W + NUM_OUTPUTS + VALS_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [TS_W-1:0]   ts_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              overflow_reg;
  logic [1:0]        state_reg;
  logic              m_valid_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [REC_W-1:0]  sh_rec_reg;

  logic [REC_W-1:0]  mem [DEPTH];

  logic              push_req;
  logic              fifo_full;
  logic              push;
  logic              drop;
  logic              pop;

  logic [TS_W-1:0]        sh_ts;
  logic [NUM_OUTPUTS-1:0] sh_mask;
  logic [VALS_W-1:0]      sh_vals;
  logic [DATA_W-1:0]      val_arr [NUM_OUTPUTS];

  logic [IDX_W-1:0]  first_idx;
  logic [IDX_W-1:0]  next_idx;
  logic              next_found;
  logic [DATA_W-1:0] hdr_word;
  logic [DATA_W-1:0] m_data_next;

`ifdef COLLECTOR_DROP_CNT_EN
  logic        gap_pending_reg;
  logic        hdr_gap_reg;
  logic [15:0] drop_cnt_reg;
`endif

  // Full is judged on pre-pop occupancy, so a same-cycle pop never rescues a push.
  assign push_req  = en & (|out_aktv);
  assign fifo_full = (count_reg == (AW+1)'(DEPTH));
  assign push      = push_req & ~fifo_full;
  assign drop      = push_req & fifo_full;
  assign pop       = (state_reg == ST_IDLE) && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {ts_reg, out_aktv, out_val};
    end
  end

  // Registered read straight into the shadow so the RAM output is the shadow itself.
  always_ff @(posedge clk) begin
    if (pop) begin
      sh_rec_reg <= mem[rd_ptr_reg];
    end
  end

  assign sh_ts   = sh_rec_reg[REC_W-1 -: TS_W];
  assign sh_mask = sh_rec_reg[VALS_W +: NUM_OUTPUTS];
  assign sh_vals = sh_rec_reg[VALS_W-1:0];

  generate
    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_val
      assign val_arr[gi] = sh_vals[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Descending scan: the final hit is the lowest qualifying index.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
      if (sh_mask[i]) begin
        first_idx = IDX_W'(i);
      end
      if (sh_mask[i] && (i > int'(idx_reg))) begin
        next_idx   = IDX_W'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    hdr_word = '0;
    hdr_word[DATA_W-1 -: TS_W]   = sh_ts;
    hdr_word[NUM_OUTPUTS-1:0]    = sh_mask;
`ifdef COLLECTOR_DROP_CNT_EN
    hdr_word[NUM_OUTPUTS]        = hdr_gap_reg;
`endif
  end

  always_comb begin
    m_data_next = '0;
    if (m_valid_reg) begin
      if (state_reg == ST_HDR) begin
        m_data_next = hdr_word;
      end else if (state_reg == ST_DATA) begin
        m_data_next = val_arr[idx_reg];
      end
    end
  end

  assign m_data     = m_data_next;
  assign m_valid    = m_valid_reg;
  assign m_last     = m_valid_reg && (state_reg == ST_DATA) && !next_found;
  assign overflow   = overflow_reg;
  assign fifo_level = count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_reg       <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= ST_IDLE;
      m_valid_reg  <= 1'b0;
      idx_reg      <= '0;
    end else begin
      if (en) begin
        ts_reg <= ts_reg + TS_W'(1);
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          m_valid_reg <= 1'b0;
          if (pop) begin
            state_reg <= ST_HDR;
          end
        end
        ST_HDR: begin
          // First HDR cycle only raises valid; header goes out from the following cycle.
          if (!m_valid_reg) begin
            m_valid_reg <= 1'b1;
          end else if (m_ready) begin
            idx_reg   <= first_idx;
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_ready) begin
            if (next_found) begin
              idx_reg <= next_idx;
            end else begin
              m_valid_reg <= 1'b0;
              state_reg   <= ST_IDLE;
            end
          end
        end
        default: begin
          m_valid_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef COLLECTOR_DROP_CNT_EN
  // The marker is committed to a record when it is popped; pending restarts for later drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_pending_reg <= 1'b0;
      hdr_gap_reg     <= 1'b0;
      drop_cnt_reg    <= '0;
    end else begin
      if (pop) begin
        hdr_gap_reg     <= gap_pending_reg | drop;
        gap_pending_reg <= 1'b0;
      end else if (drop) begin
        gap_pending_reg <= 1'b1;
      end
      if (drop && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_verdict_stream_collector.sv
// Directed bench for verdict_stream_collector: table of single records plus stall, overflow, pause and reset sequences.
module tb_verdict_stream_collector;

  localparam int NO    = 3;
  localparam int DW    = 64;
  localparam int TW    = 32;
  localparam int DEPTH = 16;
`ifdef COLLECTOR_DROP_CNT_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [NO*DW-1:0] out_val;
  logic [NO-1:0]  out_aktv;
  logic [DW-1:0]  m_data;
  logic           m_valid;
  logic           m_last;
  logic           m_ready;
  logic           overflow;
  logic [4:0]     fifo_level;
`ifdef COLLECTOR_DROP_CNT_EN
  logic [15:0]    drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [TW-1:0] ts_model;

  verdict_stream_collector #(
    .NUM_OUTPUTS(NO), .DATA_W(DW), .TS_W(TW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .out_val(out_val), .out_aktv(out_aktv),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .overflow(overflow), .fifo_level(fifo_level)
`ifdef COLLECTOR_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference timestamp: counts enabled edges, cleared by reset.
  always @(posedge clk) begin
    if (!rst) ts_model <= '0;
    else if (en) ts_model <= ts_model + 32'd1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  aktv;
    logic [63:0] v0, v1, v2;
    int          nval;
    logic [63:0] e0, e1, e2;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [31:0] ts, input logic [2:0] mask, input logic gap);
    return {ts, 28'd0, gap, mask};
  endfunction

  task automatic get_word(output logic [63:0] d, output logic l);
    int n;
    n = 0;
    m_ready = 1'b1;
    while (!m_valid && n < 40) begin
      tick();
      n++;
    end
    if (!m_valid) begin
      checks++;
      errors++;
      $display("FAIL word_timeout: got m_valid=0 required m_valid=1 within 40 cycles");
      d = '0;
      l = 1'b0;
    end else begin
      d = m_data;
      l = m_last;
      $display("word data=%h last=%0d", d, l);
      tick();
    end
  endtask

  task automatic run_expect(input string name, input logic [31:0] ts, input logic [2:0] mask,
                            input logic gap, input int nval,
                            input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2);
    logic [63:0] d;
    logic        l;
    logic [63:0] ev[3];
    ev[0] = e0;
    ev[1] = e1;
    ev[2] = e2;
    get_word(d, l);
    check({name, "_hdr"}, d, hdr(ts, mask, gap));
    check({name, "_hdr_last"}, 64'(l), 64'd0);
    for (int k = 0; k < nval; k++) begin
      get_word(d, l);
      check($sformatf("%s_val%0d", name, k), d, ev[k]);
      check($sformatf("%s_last%0d", name, k), 64'(l), (k == nval - 1) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    logic [31:0] cap_ts;
    logic [31:0] pre_ts;
    logic [31:0] burst_ts;
    logic [63:0] d;
    logic        l;

    tbl[0] = '{3'b100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1,
               64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0};
    tbl[1] = '{3'b101, 64'h8000_0000_0000_0001, 64'd77, 64'h1234, 2,
               64'h8000_0000_0000_0001, 64'h1234, 64'd0};
    tbl[2] = '{3'b011, 64'hDEAD_BEEF_0000_0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 2,
               64'hDEAD_BEEF_0000_0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    tbl[3] = '{3'b001, 64'd3, 64'd4, 64'd5, 1, 64'd3, 64'd0, 64'd0};
    tbl[4] = '{3'b110, 64'd99, 64'd22, 64'd33, 2, 64'd22, 64'd33, 64'd0};
    tbl[5] = '{3'b111, 64'd10, 64'd20, 64'd30, 3, 64'd10, 64'd20, 64'd30};

    rst = 1'b0; en = 1'b0; m_ready = 1'b0; out_aktv = '0; out_val = '0;
    tick();
    tick();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);

    // Five enabled idle cycles, then all three streams at ts=5.
    rst = 1'b1; en = 1'b1;
    repeat (5) tick();
    out_aktv = 3'b111;
    out_val = {64'd1, 64'd1, 64'd1};
    tick();
    out_aktv = '0;
    out_val = {3{64'hA5A5_A5A5_A5A5_A5A5}};
    check("lat_e0_valid", 64'(m_valid), 64'd0);
    check("lat_e0_level", 64'(fifo_level), 64'd1);
    tick();
    check("lat_e1_valid", 64'(m_valid), 64'd0);
    check("lat_e1_level", 64'(fifo_level), 64'd0);
    tick();
    check("lat_e2_valid", 64'(m_valid), 64'd1);
    run_expect("rec111", 32'd5, 3'b111, 1'b0, 3, 64'd1, 64'd1, 64'd1);

    // Stall with m_ready low: header must stay put.
    m_ready = 1'b0;
    out_aktv = 3'b010;
    out_val = {64'd0, 64'd6, 64'd0};
    cap_ts = ts_model;
    tick();
    out_aktv = '0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 64'(m_valid), 64'd1);
      check("stall_data", m_data, hdr(cap_ts, 3'b010, 1'b0));
      check("stall_last", 64'(m_last), 64'd0);
      tick();
    end
    run_expect("stall", cap_ts, 3'b010, 1'b0, 1, 64'd6, 64'd0, 64'd0);
    tick();
    check("stall_level_end", 64'(fifo_level), 64'd0);
    check("stall_valid_end", 64'(m_valid), 64'd0);

    for (int i = 0; i < 6; i++) begin
      out_aktv = tbl[i].aktv;
      out_val = {tbl[i].v2, tbl[i].v1, tbl[i].v0};
      cap_ts = ts_model;
      tick();
      out_aktv = '0;
      out_val = {3{64'hA5A5_A5A5_A5A5_A5A5}};
      run_expect($sformatf("tbl%0d", i), cap_ts, tbl[i].aktv, 1'b0, tbl[i].nval,
                 tbl[i].e0, tbl[i].e1, tbl[i].e2);
    end

    // Pause: en low for 7 cycles with toggling flags.
    tick();
    pre_ts = ts_model;
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_aktv = (i % 2 == 1) ? 3'b111 : 3'b101;
      out_val = {64'(i), 64'(i + 1), 64'(i + 2)};
      tick();
    end
    out_aktv = '0;
    check("pause_level", 64'(fifo_level), 64'd0);
    check("pause_valid", 64'(m_valid), 64'd0);
    en = 1'b1;
    repeat (3) tick();
    out_aktv = 3'b001;
    out_val = {64'd0, 64'd0, 64'd42};
    tick();
    out_aktv = '0;
    run_expect("pause", pre_ts + 32'd3, 3'b001, 1'b0, 1, 64'd42, 64'd0, 64'd0);

    // Overflow: hold one record in the header stage, then 18 back-to-back captures.
    m_ready = 1'b0;
    out_aktv = 3'b001;
    out_val = {64'd0, 64'd0, 64'd100};
    cap_ts = ts_model;
    tick();
    out_aktv = '0;
    tick();
    tick();
    check("ovf_hold_valid", 64'(m_valid), 64'd1);
    check("ovf_hold_level", 64'(fifo_level), 64'd0);
    burst_ts = ts_model;
    for (int i = 0; i < 18; i++) begin
      out_aktv = 3'b010;
      out_val = {64'd0, 64'(i), 64'd0};
      tick();
      if (i == 15) begin
        check("ovf_level_16", 64'(fifo_level), 64'd16);
        check("ovf_not_yet", 64'(overflow), 64'd0);
      end
      if (i == 16) begin
        check("ovf_level_17", 64'(fifo_level), 64'd16);
        check("ovf_set", 64'(overflow), 64'd1);
      end
    end
    out_aktv = '0;
    tick();
    tick();
    check("ovf_level_final", 64'(fifo_level), 64'd16);
    check("ovf_sticky", 64'(overflow), 64'd1);
`ifdef COLLECTOR_DROP_CNT_EN
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
`endif
    run_expect("ovf_r0", cap_ts, 3'b001, 1'b0, 1, 64'd100, 64'd0, 64'd0);
    for (int k = 0; k < 16; k++) begin
      run_expect($sformatf("ovf_b%0d", k), burst_ts + 32'(k), 3'b010, GAP_EN && (k == 0), 1,
                 64'(k), 64'd0, 64'd0);
    end
    repeat (4) tick();
    check("ovf_drained_level", 64'(fifo_level), 64'd0);
    check("ovf_drained_valid", 64'(m_valid), 64'd0);
    check("ovf_still_sticky", 64'(overflow), 64'd1);

    // Reset in the middle of a record with another record queued.
    m_ready = 1'b0;
    out_aktv = 3'b111;
    out_val = {64'd9, 64'd8, 64'd7};
    tick();
    out_aktv = 3'b001;
    out_val = {64'd0, 64'd0, 64'd77};
    tick();
    out_aktv = '0;
    get_word(d, l);
    get_word(d, l);
    m_ready = 1'b0;
    check("mid_valid", 64'(m_valid), 64'd1);
    check("mid_data", m_data, 64'd8);
    rst = 1'b0;
    tick();
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    check("mid_rst_last", 64'(m_last), 64'd0);
    check("mid_rst_data", m_data, 64'd0);
    rst = 1'b1;
    en = 1'b1;
    out_aktv = 3'b100;
    out_val = {64'd55, 64'd0, 64'd0};
    tick();
    out_aktv = '0;
    run_expect("post_rst", 32'd0, 3'b100, 1'b0, 1, 64'd55, 64'd0, 64'd0);
    repeat (6) tick();
    check("post_rst_no_stale", 64'(m_valid), 64'd0);
    check("post_rst_level", 64'(fifo_level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
